// File: rtl/alarme_pkg.sv
// alarme_pkg: state encoding, default timing values and a helper for the seat-belt alarm
package alarme_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ALERTA   = 2'd1,
        BIP      = 2'd2,
        SILENCIO = 2'd3
    } estado_t;

    localparam int DIV_TICK_PADRAO = 4;
    localparam int T_ALERTA_PADRAO = 3;
    localparam int T_BIP_PADRAO    = 5;

    function automatic int maximo(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// divisor_tick: prescaler that pulses tick once every DIV_TICK cycles, cleared synchronously by limpa
module divisor_tick
    import alarme_pkg::*;
#(
    parameter int DIV_TICK = DIV_TICK_PADRAO
) (
    input  logic clk,
    input  logic rst_n,
    input  logic limpa,
    output logic tick
);
    localparam int W = DIV_TICK > 1 ? $clog2(DIV_TICK) : 1;
    localparam logic [W-1:0] ULTIMO = W'(DIV_TICK - 1);

    logic [W-1:0] cont_q, cont_d;

    assign tick = cont_q == ULTIMO;

    // count 0..DIV_TICK-1, wrap after the tick cycle, restart on clear
    always_comb cont_d = limpa || tick ? '0 : cont_q + 1'b1;

    // prescaler register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cont_q <= '0;
        else cont_q <= cont_d;

endmodule

// File: rtl/controle_alarme_cinto.sv
// controle_alarme_cinto: timed seat-belt warning FSM (light, light+buzzer, steady light); ALARME_PISCA_EN makes the light blink during BIP
module controle_alarme_cinto
    import alarme_pkg::*;
#(
    parameter int DIV_TICK = DIV_TICK_PADRAO,
    parameter int T_ALERTA = T_ALERTA_PADRAO,
    parameter int T_BIP    = T_BIP_PADRAO
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       motorista_presente,
    input  logic       cinto_em_uso,
    input  logic       ignicao_ligada,
    output logic       luz_de_advertencia,
    output logic       buzina,
    output logic [1:0] estado
);
    localparam int TW = $clog2(maximo(T_ALERTA, T_BIP) + 1);
    localparam logic [TW-1:0] FIM_ALERTA = TW'(T_ALERTA - 1);
    localparam logic [TW-1:0] FIM_BIP    = TW'(T_BIP - 1);

    estado_t       estado_q, estado_d;
    logic [TW-1:0] ticks_q, ticks_d;
    logic          luz_q, luz_d, buzina_q, buzina_d;
    logic          cond, tick, limpa;

    assign cond  = motorista_presente & ~cinto_em_uso & ignicao_ligada;
    assign limpa = estado_d != estado_q || estado_q == OCIOSO;

    divisor_tick #(.DIV_TICK(DIV_TICK)) u_divisor (
        .clk   (clk),
        .rst_n (rst_n),
        .limpa (limpa),
        .tick  (tick)
    );

    // next state, tick count and output decode; a dropped cond wins over any timer expiry
    always_comb begin
        estado_d = !cond                                              ? OCIOSO   :
                   estado_q == OCIOSO                                 ? ALERTA   :
                   estado_q == ALERTA && tick && ticks_q == FIM_ALERTA ? BIP      :
                   estado_q == BIP && tick && ticks_q == FIM_BIP       ? SILENCIO : estado_q;
        ticks_d  = limpa ? '0 : tick && ~&ticks_q ? ticks_q + 1'b1 : ticks_q;
`ifdef ALARME_PISCA_EN
        luz_d    = estado_d == BIP && estado_q == BIP ? luz_q ^ tick : estado_d != OCIOSO;
`else
        luz_d    = estado_d != OCIOSO;
`endif
        buzina_d = estado_d == BIP;
    end

    // state, tick counter and registered Moore outputs
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            estado_q <= OCIOSO;
            ticks_q  <= '0;
            luz_q    <= 1'b0;
            buzina_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            ticks_q  <= ticks_d;
            luz_q    <= luz_d;
            buzina_q <= buzina_d;
        end

    assign luz_de_advertencia = luz_q;
    assign buzina             = buzina_q;
    assign estado             = estado_q;

endmodule

// File: tb/tb_controle_alarme_cinto.sv
// tb_controle_alarme_cinto: scoreboard bench for the seat-belt alarm with a cycle-counting reference model
module tb_controle_alarme_cinto;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m = 1'b0, c = 1'b0, i = 1'b0;
    logic       luz, buz;
    logic [1:0] est;

    typedef struct {
        logic [1:0] e;
        logic       l;
        logic       b;
    } esperado_t;

    esperado_t fila[$];
    int passou = 0;
    int total  = 0;
    int st     = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    controle_alarme_cinto dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .motorista_presente (m),
        .cinto_em_uso       (c),
        .ignicao_ligada     (i),
        .luz_de_advertencia (luz),
        .buzina             (buz),
        .estado             (est)
    );

    task automatic confere(input string tag, input int obs, input int esp);
        total++;
        if (obs == esp) passou++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    endtask

    task automatic modelo(input logic mm, input logic cc, input logic ii);
        int n;
        if (!(mm && !cc && ii)) begin
            st  = 0;
            cyc = 0;
        end else if (st == 0) begin
            st  = 1;
            cyc = 0;
        end else begin
            n = cyc + 1;
            if ((st == 1 && n == 12) || (st == 2 && n == 20)) begin
                st  = st + 1;
                cyc = 0;
            end else cyc = n;
        end
    endtask

    function automatic logic luz_modelo();
`ifdef ALARME_PISCA_EN
        if (st == 2) return (cyc / 4) % 2 == 0;
`endif
        return st != 0;
    endfunction

    task automatic passo(input logic mm, input logic cc, input logic ii, input string tag);
        esperado_t x;
        m = mm;
        c = cc;
        i = ii;
        modelo(mm, cc, ii);
        x.e = 2'(st);
        x.l = luz_modelo();
        x.b = st == 2;
        fila.push_back(x);
        @(posedge clk);
        #1;
        x = fila.pop_front();
        confere({tag, ".estado"}, int'(est), int'(x.e));
        confere({tag, ".luz"}, int'(luz), int'(x.l));
        confere({tag, ".buzina"}, int'(buz), int'(x.b));
    endtask

    initial begin
        logic saiu;
        logic [2:0] v;
        repeat (2) @(posedge clk);
        #1;
        confere("reset.estado", int'(est), 0);
        confere("reset.luz", int'(luz), 0);
        confere("reset.buzina", int'(buz), 0);
        rst_n = 1'b1;

        passo(1'b0, 1'b0, 1'b1, "idle");
        repeat (40) passo(1'b1, 1'b0, 1'b1, "escalada");
        passo(1'b1, 1'b1, 1'b1, "cinto_silencio");

        repeat (18) passo(1'b1, 1'b0, 1'b1, "ate_bip5");
        passo(1'b1, 1'b1, 1'b1, "cinto_bip");

        repeat (12) passo(1'b1, 1'b0, 1'b1, "ate_tick3");
        passo(1'b1, 1'b0, 1'b0, "simultaneo");

        repeat (21) passo(1'b1, 1'b0, 1'b1, "ate_bip8");
        #2;
        rst_n = 1'b0;
        #1;
        confere("rst_async.estado", int'(est), 0);
        confere("rst_async.luz", int'(luz), 0);
        confere("rst_async.buzina", int'(buz), 0);
        st  = 0;
        cyc = 0;
        @(posedge clk);
        #1;
        confere("rst_hold.estado", int'(est), 0);
        rst_n = 1'b1;
        repeat (36) passo(1'b1, 1'b0, 1'b1, "rearme");

        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            passo(1'b0, 1'b0, 1'b0, "sweep_idle");
            saiu = 1'b0;
            for (int j = 0; j < 40; j++) begin
                passo(v[2], v[1], v[0], "sweep");
                saiu |= est != 2'd0;
            end
            confere($sformatf("sweep_sai_%0d", k), int'(saiu), int'(k == 5));
        end

        $display("%0d/%0d checks passed", passou, total);
        $finish;
    end

endmodule

// File: doc/controle_alarme_cinto.md
# controle_alarme_cinto

Sequential controller for the seat-belt warning system. It samples driver presence, belt use and ignition state, then drives the warning light and a buzzer through a timed escalation: light first, then light plus buzzer, then a silent steady light. It replaces the purely combinational warning-light decode wherever a clocked, time-limited alarm is required.

## Interface
- `DIV_TICK`, default 4: clock cycles per time tick (≥1).
- `T_ALERTA`, default 3: ticks spent in light-only alert before the buzzer starts (≥1).
- `T_BIP`, default 5: ticks of buzzer activity before silencing (≥1).
- `clk`  input  1  single system clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `motorista_presente`  input  1  driver seated; synchronous to `clk`.
- `cinto_em_uso`  input  1  belt fastened; synchronous to `clk`.
- `ignicao_ligada`  input  1  ignition on; synchronous to `clk`.
- `luz_de_advertencia`  output  1  warning light.
- `buzina`  output  1  buzzer enable.
- `estado`  output  2  current FSM state, for debug and bench visibility.

## Operation
- Alarm condition: `cond = motorista_presente & ~cinto_em_uso & ignicao_ligada`.
- FSM states and encodings:
  - OCIOSO = 0
  - ALERTA = 1
  - BIP = 2
  - SILENCIO = 3
- Transitions, evaluated at each rising edge:
  - OCIOSO → ALERTA when `cond`=1.
  - ALERTA → OCIOSO when `cond`=0. Otherwise ALERTA → BIP on the T_ALERTA-th tick.
  - BIP → OCIOSO when `cond`=0. Otherwise BIP → SILENCIO on the T_BIP-th tick.
  - SILENCIO → OCIOSO when `cond`=0. Otherwise it stays in SILENCIO indefinitely.
- Priority: `cond`=0 overrides timer expiry in the same cycle; the FSM goes to OCIOSO.
- Tick generation:
  - Prescaler counts 0..DIV_TICK-1 and asserts `tick` in the cycle it holds DIV_TICK-1, then wraps to 0.
  - Prescaler and tick counter both clear on every state change and while in OCIOSO.
- Tick counter width is `$clog2(max(T_ALERTA,T_BIP)+1)`. It saturates and never wraps.
- Outputs are Moore outputs, decoded from registered state. No combinational input-to-output path.
  - OCIOSO: luz=0, buzina=0.
  - ALERTA: luz=1, buzina=0.
  - BIP: luz=1 (see Configuration), buzina=1.
  - SILENCIO: luz=1, buzina=0.
- Re-arming: after a return to OCIOSO, a new `cond` restarts the full sequence from ALERTA.

## Timing
- Reset values: `estado`=0, `luz_de_advertencia`=0, `buzina`=0, prescaler=0, tick counter=0. Reset takes effect immediately and asynchronously, including mid-BIP; outputs fall without waiting for a clock edge.
- Latency: `cond` sampled high at edge k → `luz_de_advertencia`=1 after edge k.
- ALERTA lasts exactly T_ALERTA·DIV_TICK cycles. With defaults that is 12 cycles.
- BIP lasts exactly T_BIP·DIV_TICK cycles. With defaults that is 20 cycles.
- `cond` sampled low at edge k → OCIOSO after edge k, with all outputs 0 in the next cycle.
- First edge after reset release: ordinary sampling. No extra wait state.

## Configuration
- `ALARME_PISCA_EN` defined:
  - In BIP the light blinks. `luz_de_advertencia` is 1 on entry and toggles at each tick.
  - With defaults (T_BIP=5) the light is 1,0,1,0,1 per tick period; it is forced to 1 on entry to SILENCIO.
- `ALARME_PISCA_EN` undefined: light is steady 1 throughout BIP, and no toggle register is built.

## Structure
- Package `alarme_pkg` holds:
  - the state encoding `estado_t` (OCIOSO, ALERTA, BIP, SILENCIO);
  - the default values of DIV_TICK, T_ALERTA and T_BIP.
- Sub-module `divisor_tick` contains the prescaler.
  - Parameter: DIV_TICK.
  - Ports: `clk`, `rst_n`, synchronous clear `limpa`, output `tick`.
- The FSM, tick counter and output decode stay in the top module.

## Test plan
All scenarios use default parameters.
- **Full escalation.** Set `motorista`=1, `cinto`=0, `ignicao`=1 and hold.
  - luz=1 one edge later.
  - buzina=1 after 12 cycles.
  - buzina=0 after a further 20 cycles with `estado`=3; luz stays 1.
- **Belt fastened during BIP.** Drive `cinto`=1 at cycle 5 of BIP → `estado`=0, luz=0, buzina=0 after the next edge.
- **Simultaneous events.** Drop `ignicao` on the same edge as the 3rd ALERTA tick → `estado`=0, not 2.
- **Reset mid-operation.** Pulse `rst_n`=0 mid-BIP.
  - Outputs go to 0 without a clock edge.
  - After release with `cond` still 1: ALERTA is re-entered and lasts the full 12 cycles.
- **Blink (`ALARME_PISCA_EN` defined).** Light toggles every 4 cycles during BIP: 1,0,1,0,1. luz=1 in SILENCIO.
- **Truth sweep.** Sweep all 8 input combinations for 40 cycles each → only combination 101 leaves OCIOSO.
